// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with one power-of-two shift stage per register, on a valid/ready stream.
// Define BSHIFT_CARRY_EN to build out_carry, which is the last bit shifted or rotated out.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
`ifdef BSHIFT_CARRY_EN
    ,
    output logic                     out_carry
`endif
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    logic             w_advance;
    // Index i is the input of stage i; index SHW is the output of the last stage.
    logic [WIDTH-1:0] w_stg_data  [SHW+1];
    logic [SHW-1:0]   w_stg_amt   [SHW];
    logic [2:0]       w_stg_op    [SHW];
    logic [SHW:0]     w_stg_valid;
`ifdef BSHIFT_CARRY_EN
    logic [SHW:0]     w_stg_carry;
`endif

    assign w_advance      = !w_stg_valid[SHW] || out_ready;
    assign in_ready       = w_advance;

    assign w_stg_data[0]  = in_data;
    assign w_stg_amt[0]   = in_amt;
    assign w_stg_op[0]    = in_op;
    assign w_stg_valid[0] = in_valid;

    assign out_valid      = w_stg_valid[SHW];
    assign out_data       = w_stg_data[SHW];

`ifdef BSHIFT_CARRY_EN
    assign w_stg_carry[0] = 1'b0;
    assign out_carry      = w_stg_carry[SHW];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int S = 1 << gi;

            logic [WIDTH-1:0] w_shift_data;
            logic [WIDTH-1:0] r_data;
            logic             r_valid;

            always_comb begin
                w_shift_data = w_stg_data[gi];
                if (w_stg_amt[gi][gi]) begin
                    case (w_stg_op[gi])
                        OP_ROL:  w_shift_data = {w_stg_data[gi][WIDTH-1-S:0], w_stg_data[gi][WIDTH-1:WIDTH-S]};
                        OP_ROR:  w_shift_data = {w_stg_data[gi][S-1:0], w_stg_data[gi][WIDTH-1:S]};
                        OP_SLL:  w_shift_data = {w_stg_data[gi][WIDTH-1-S:0], {S{1'b0}}};
                        OP_SRL:  w_shift_data = {{S{1'b0}}, w_stg_data[gi][WIDTH-1:S]};
                        // Earlier stages keep the MSB intact, so it is still the operand's sign.
                        OP_SRA:  w_shift_data = {{S{w_stg_data[gi][WIDTH-1]}}, w_stg_data[gi][WIDTH-1:S]};
                        default: w_shift_data = w_stg_data[gi];
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_advance) begin
                    r_valid <= w_stg_valid[gi];
                    r_data  <= w_shift_data;
                end
            end

            assign w_stg_valid[gi+1] = r_valid;
            assign w_stg_data[gi+1]  = r_data;

            // Amount and op are only needed by later stages, so the last stage does not register them.
            if (gi < SHW - 1) begin : g_ctl
                logic [SHW-1:0] r_amt;
                logic [2:0]     r_op;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_amt <= '0;
                        r_op  <= '0;
                    end else if (w_advance) begin
                        r_amt <= w_stg_amt[gi];
                        r_op  <= w_stg_op[gi];
                    end
                end

                assign w_stg_amt[gi+1] = r_amt;
                assign w_stg_op[gi+1]  = r_op;
            end

`ifdef BSHIFT_CARRY_EN
            logic w_shift_carry;
            logic r_carry;

            always_comb begin
                w_shift_carry = w_stg_carry[gi];
                if (w_stg_amt[gi][gi]) begin
                    case (w_stg_op[gi])
                        OP_ROL, OP_SLL:         w_shift_carry = w_stg_data[gi][WIDTH-S];
                        OP_ROR, OP_SRL, OP_SRA: w_shift_carry = w_stg_data[gi][S-1];
                        default:                w_shift_carry = w_stg_carry[gi];
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_carry <= 1'b0;
                end else if (w_advance) begin
                    r_carry <= w_shift_carry;
                end
            end

            assign w_stg_carry[gi+1] = r_carry;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: table vectors and random streams through a scoreboard on an 8-bit instance,
// plus direct latency and result checks on a 32-bit instance.
module tb_pipelined_barrel_shifter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_data, out_data;
    logic [2:0]  in_amt, in_op;

    logic        in32_valid, in32_ready, out32_valid, out32_ready;
    logic [31:0] in32_data, out32_data;
    logic [4:0]  in32_amt;
    logic [2:0]  in32_op;
`ifdef BSHIFT_CARRY_EN
    logic        out_carry, out32_carry;
`endif

    pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BSHIFT_CARRY_EN
        ,
        .out_carry (out_carry)
`endif
    );

    pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in32_valid),
        .in_ready  (in32_ready),
        .in_data   (in32_data),
        .in_amt    (in32_amt),
        .in_op     (in32_op),
        .out_valid (out32_valid),
        .out_ready (out32_ready),
        .out_data  (out32_data)
`ifdef BSHIFT_CARRY_EN
        ,
        .out_carry (out32_carry)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        int         id;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [2:0] amt;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_carry;
    } vec_t;

    exp_t sb[$];
    exp_t cur_exp;
    vec_t vecs[12];
    int   popped = 0;
    bit   accepted;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: whole-amount shift on a w-bit value; returns {carry, data}.
    function automatic logic [32:0] model(input int w, input logic [2:0] op, input int n, input logic [31:0] d);
        logic [63:0] x, mask, r;
        logic        c;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, d} & mask;
        r    = x;
        c    = 1'b0;
        if (n != 0) begin
            case (op)
                3'd0: begin r = ((x << n) | (x >> (w - n))) & mask; c = x[w-n]; end
                3'd1: begin r = ((x >> n) | (x << (w - n))) & mask; c = x[n-1]; end
                3'd2: begin r = (x << n) & mask;                    c = x[w-n]; end
                3'd3: begin r = x >> n;                             c = x[n-1]; end
                3'd4: begin r = (x >> n) | (x[w-1] ? (mask ^ (mask >> n)) : 64'd0); c = x[n-1]; end
                default: begin r = x; c = 1'b0; end
            endcase
        end
        return {c, r[31:0]};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d,
                         input logic [7:0] ed, input logic ec, input int id);
        in_valid      = 1'b1;
        in_op         = op;
        in_amt        = amt;
        in_data       = d;
        cur_exp.data  = ed;
        cur_exp.carry = ec;
        cur_exp.id    = id;
    endtask

    task automatic drive_model(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d, input int id);
        logic [32:0] m;
        m = model(8, op, int'(amt), {24'd0, d});
        drive(op, amt, d, m[7:0], m[32], id);
    endtask

    // One clock: sample both handshakes away from the edge, then advance to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=beat %0h required=no beat", out_data);
            end else begin
                e = sb.pop_front();
                popped++;
                check($sformatf("beat%0d_data", e.id), out_data, e.data);
`ifdef BSHIFT_CARRY_EN
                check($sformatf("beat%0d_carry", e.id), out_carry, e.carry);
`endif
            end
        end
        if (accepted) sb.push_back(cur_exp);
        @(negedge clk);
    endtask

    task automatic run32(input string name, input logic [2:0] op, input logic [4:0] amt,
                         input logic [31:0] d, input logic [31:0] ed, input logic ec);
        int lat;
        in32_valid = 1'b1;
        in32_op    = op;
        in32_amt   = amt;
        in32_data  = d;
        @(posedge clk);
        #1;
        in32_valid = 1'b0;
        lat = 1;
        while (!out32_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, 5);
        check({name, "_data"}, out32_data, ed);
`ifdef BSHIFT_CARRY_EN
        check({name, "_carry"}, out32_carry, ec);
`else
        if (ec === 1'bx) $display("note: carry expectation undefined for %s", name);
`endif
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int lat, guard, pop0, idx, cyc, stale;
        logic [7:0] bp_data [12];
        logic [2:0] bp_op   [12];
        logic [2:0] bp_amt  [12];

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_amt      = '0;
        in_op       = '0;
        out_ready   = 1'b1;
        in32_valid  = 1'b0;
        in32_data   = '0;
        in32_amt    = '0;
        in32_op     = '0;
        out32_ready = 1'b1;
        cur_exp     = '{data: 8'h00, carry: 1'b0, id: 0};

        vecs[0]  = '{3'd0, 3'd3, 8'hA5, 8'h2D, 1'b1};
        vecs[1]  = '{3'd4, 3'd2, 8'h90, 8'hE4, 1'b0};
        vecs[2]  = '{3'd3, 3'd2, 8'h90, 8'h24, 1'b0};
        vecs[3]  = '{3'd2, 3'd1, 8'h81, 8'h02, 1'b1};
        vecs[4]  = '{3'd1, 3'd3, 8'hA5, 8'hB4, 1'b1};
        vecs[5]  = '{3'd0, 3'd0, 8'h81, 8'h81, 1'b0};
        vecs[6]  = '{3'd5, 3'd5, 8'h3C, 8'h3C, 1'b0};
        vecs[7]  = '{3'd4, 3'd7, 8'h7F, 8'h00, 1'b1};
        vecs[8]  = '{3'd4, 3'd7, 8'h80, 8'hFF, 1'b0};
        vecs[9]  = '{3'd2, 3'd7, 8'hFF, 8'h80, 1'b1};
        vecs[10] = '{3'd1, 3'd1, 8'h01, 8'h80, 1'b1};
        vecs[11] = '{3'd3, 3'd7, 8'h80, 8'h01, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat: latency from acceptance to out_valid.
        drive(vecs[0].op, vecs[0].amt, vecs[0].data, vecs[0].exp_data, vecs[0].exp_carry, 0);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency_w8", lat, 3);
        tick();

        // Remaining table vectors back to back.
        for (int i = 1; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].exp_data, vecs[i].exp_carry, i);
            tick();
        end
        in_valid = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("table_drained", sb.size(), 0);

        // 16 random beats at full rate: all must be out three cycles after the last is accepted.
        pop0 = popped;
        for (int i = 0; i < 16; i++) begin
            drive_model(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom), 100 + i);
            tick();
            check($sformatf("stream_accept%0d", i), accepted, 1'b1);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("stream_throughput", popped - pop0, 16);

        // Backpressure: out_ready low for 5 cycles mid-burst.
        for (int i = 0; i < 12; i++) begin
            bp_data[i] = 8'($urandom);
            bp_op[i]   = 3'($urandom_range(0, 7));
            bp_amt[i]  = 3'($urandom_range(1, 7));
        end
        pop0 = popped;
        idx  = 0;
        cyc  = 0;
        while ((idx < 12 || sb.size() > 0) && cyc < 200) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (idx < 12) drive_model(bp_op[idx], bp_amt[idx], bp_data[idx], 200 + idx);
            else in_valid = 1'b0;
            #1;
            if (out_valid && !out_ready && sb.size() > 0) begin
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_data_hold", out_data, sb[0].data);
            end
            tick();
            if (accepted) idx++;
            cyc++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check("bp_all_delivered", popped - pop0, 12);
        check("bp_sb_empty", sb.size(), 0);

        // Reset with three beats in flight.
        drive(3'd0, 3'd1, 8'h5A, 8'hB4, 1'b0, 300);
        tick();
        drive(3'd2, 3'd2, 8'h33, 8'hCC, 1'b0, 301);
        tick();
        drive(3'd1, 3'd4, 8'h0F, 8'hF0, 1'b1, 302);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_out_data", out_data, 8'h00);
`ifdef BSHIFT_CARRY_EN
        check("rst_mid_out_carry", out_carry, 1'b0);
`endif
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1'b1);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) stale++;
            tick();
        end
        check("rst_no_stale_beats", stale, 0);

        // 32-bit instance.
        run32("w32_ror31", 3'd1, 5'd31, 32'h0000_0001, 32'h0000_0002, 1'b0);
        run32("w32_pass7", 3'd7, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        run32("w32_sra31", 3'd4, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run32("w32_rol1", 3'd0, 5'd1, 32'h8000_0001, 32'h0000_0003, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
